// File: rtl/hazard_fwd_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit_if
//   Bundles the decode-side inputs and the hazard/forwarding outputs of
//   hazard_fwd_unit.
//
//   Signals:
//     Rn_0, Rm_0      decode-stage source registers A and B
//     useRn_0/useRm_0 decode instruction actually reads Rn / Rm
//     Rd_0            decode-stage destination register
//     RegWrite_0      decode-stage RegWrite
//     MemRead_0       decode-stage MemRead (load)
//     flush           squash the decode instruction (taken branch)
//     stall           hold PC and IF/ID, bubble into ID/EX
//     fwdA, fwdB      EX operand selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//     stallCount      saturating count of stall cycles
//
//   Modports:
//     master  decode / EX-mux side (drives decode fields, consumes results)
//     slave   the hazard unit itself
// -----------------------------------------------------------------------------
interface hazard_fwd_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] Rn_0;
    logic [REG_W-1:0] Rm_0;
    logic             useRn_0;
    logic             useRm_0;
    logic [REG_W-1:0] Rd_0;
    logic             RegWrite_0;
    logic             MemRead_0;
    logic             flush;

    logic             stall;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;
    logic [CNT_W-1:0] stallCount;

    modport master (
        output Rn_0, Rm_0, useRn_0, useRm_0, Rd_0, RegWrite_0, MemRead_0, flush,
        input  stall, fwdA, fwdB, stallCount
    );

    modport slave (
        input  Rn_0, Rm_0, useRn_0, useRm_0, Rd_0, RegWrite_0, MemRead_0, flush,
        output stall, fwdA, fwdB, stallCount
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//   Shadows destination register, RegWrite and MemRead of every instruction
//   through ID/EX, EX/MEM and MEM/WB, in lockstep with the control pipeline.
//   Produces the load-use stall, the ID/EX bubble insert and the EX-stage
//   operand forwarding selects, plus a saturating stall-cycle counter.
//
//   Ports:
//     clk    clock, all state on the rising edge
//     reset  asynchronous, active-low reset
//     bus    hazard_fwd_unit_if.slave (decode inputs, stall/fwd outputs)
// -----------------------------------------------------------------------------
module hazard_fwd_unit #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_fwd_unit_if.slave   bus
);

    localparam logic [REG_W-1:0] ZERO    = REG_W'(ZERO_REG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_EXMEM   = 2'b01,
        FWD_MEMWB   = 2'b10
    } fwdSel_e;

    typedef struct packed {
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rm;
        logic             useRn;
        logic             useRm;
        logic [REG_W-1:0] rd;
        logic             regWrite;
        logic             memRead;
    } idEx_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             regWrite;
        logic             memRead;
    } exMem_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             regWrite;
    } memWb_t;

    idEx_t            idEx;
    exMem_t           exMem;
    memWb_t           memWb;
    logic [CNT_W-1:0] stallCount;

    logic    hazard;
    logic    stall;
    logic    bubble;
    fwdSel_e fwdA;
    fwdSel_e fwdB;

    // A stage writes r only if it has RegWrite, targets r, and r is not XZR.
    function automatic logic writes(input logic             regWrite,
                                    input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] r);
        return regWrite && (rd == r) && (r != ZERO);
    endfunction

    // EX/MEM is checked first so the youngest value wins.
    function automatic fwdSel_e selectFwd(input logic             useSrc,
                                          input logic [REG_W-1:0] src,
                                          input exMem_t           em,
                                          input memWb_t           mw);
        if (!useSrc)
            return FWD_REGFILE;
        else if (writes(em.regWrite, em.rd, src))
            return FWD_EXMEM;
        else if (writes(mw.regWrite, mw.rd, src))
            return FWD_MEMWB;
        else
            return FWD_REGFILE;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        hazard = 1'b0;
        if (idEx.memRead) begin
            hazard = (bus.useRn_0 && writes(idEx.regWrite, idEx.rd, bus.Rn_0)) ||
                     (bus.useRm_0 && writes(idEx.regWrite, idEx.rd, bus.Rm_0));
        end
        // A squashed decode instruction cannot be waiting on the load.
        stall  = hazard && !bus.flush;
        bubble = stall || bus.flush;
        fwdA   = selectFwd(idEx.useRn, idEx.rn, exMem, memWb);
        fwdB   = selectFwd(idEx.useRm, idEx.rm, exMem, memWb);
    end

    // NOTE: all shadow state is reset asynchronously, so stall and the
    // forwarding selects read 0 the moment reset asserts, without a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idEx       <= '0;
            exMem      <= '0;
            memWb      <= '0;
            stallCount <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value, giving a true shift register.
            if (bubble) begin
                idEx <= '0;
            end else begin
                idEx.rn       <= bus.Rn_0;
                idEx.rm       <= bus.Rm_0;
                idEx.useRn    <= bus.useRn_0;
                idEx.useRm    <= bus.useRm_0;
                idEx.rd       <= bus.Rd_0;
                idEx.regWrite <= bus.RegWrite_0;
                idEx.memRead  <= bus.MemRead_0;
            end

            exMem.rd       <= idEx.rd;
            exMem.regWrite <= idEx.regWrite;
            exMem.memRead  <= idEx.memRead;

            memWb.rd       <= exMem.rd;
            memWb.regWrite <= exMem.regWrite;

            if (stall && (stallCount != CNT_MAX))
                stallCount <= stallCount + 1'b1;
        end
    end

    assign bus.stall      = stall;
    assign bus.fwdA       = fwdA;
    assign bus.fwdB       = fwdB;
    assign bus.stallCount = stallCount;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit
//   Two units (16-bit and 2-bit stall counters) share one decode stream.
//   The reference model tracks whole instructions occupying EX, MEM and WB
//   in a queue and derives stall/forward selects from the hazard rules.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_unit;

    typedef struct packed {
        logic [4:0] rn;
        logic [4:0] rm;
        logic       useRn;
        logic       useRm;
        logic [4:0] rd;
        logic       regWrite;
        logic       memRead;
    } instr_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    hazard_fwd_unit_if #(.REG_W(5), .CNT_W(16)) busA ();
    hazard_fwd_unit_if #(.REG_W(5), .CNT_W(2))  busB ();

    hazard_fwd_unit #(.REG_W(5), .ZERO_REG(31), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    hazard_fwd_unit #(.REG_W(5), .ZERO_REG(31), .CNT_W(2)) dutSat (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: pipe[0] is the instruction in EX, [1] in MEM, [2] in WB.
    instr_t pipe[$];
    instr_t curIn    = '0;
    logic   curFlush = 1'b0;
    int     cnt16    = 0;
    int     cnt2     = 0;
    logic   lastStall = 1'b0;

    initial repeat (3) pipe.push_back('0);

    function automatic bit writer(instr_t s, logic [4:0] r);
        return s.regWrite && (s.rd == r) && (r != 5'd31);
    endfunction

    function automatic logic [1:0] expFwd(bit useSrc, logic [4:0] r);
        if (!useSrc)            return 2'b00;
        if (writer(pipe[1], r)) return 2'b01;
        if (writer(pipe[2], r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit expStall();
        bit dep;
        dep = (curIn.useRn && writer(pipe[0], curIn.rn)) ||
              (curIn.useRm && writer(pipe[0], curIn.rm));
        return pipe[0].memRead && dep && !curFlush;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model advance: a bubble enters EX on stall or flush.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe.delete();
            repeat (3) pipe.push_back('0);
            cnt16     <= 0;
            cnt2      <= 0;
            lastStall <= 1'b0;
        end else begin
            bit s;
            s = expStall();
            if (s) begin
                cnt16 <= (cnt16 == 65535) ? cnt16 : cnt16 + 1;
                cnt2  <= (cnt2 == 3) ? cnt2 : cnt2 + 1;
            end
            pipe.push_front((s || curFlush) ? instr_t'('0) : curIn);
            void'(pipe.pop_back());
            lastStall <= s;
        end
    end

    // Compare process: inputs change on negedge, outputs sampled 2 units later.
    always @(negedge clk) begin
        #2;
        check("stall",       32'(busA.stall),      32'(expStall()));
        check("stall_sat",   32'(busB.stall),      32'(expStall()));
        check("fwdA",        32'(busA.fwdA),       32'(expFwd(pipe[0].useRn, pipe[0].rn)));
        check("fwdB",        32'(busA.fwdB),       32'(expFwd(pipe[0].useRm, pipe[0].rm)));
        check("fwdA_sat",    32'(busB.fwdA),       32'(expFwd(pipe[0].useRn, pipe[0].rn)));
        check("fwdB_sat",    32'(busB.fwdB),       32'(expFwd(pipe[0].useRm, pipe[0].rm)));
        check("stallCount",  32'(busA.stallCount), 32'(cnt16));
        check("stallCount2", 32'(busB.stallCount), 32'(cnt2));
        // A load in MEM feeding EX directly means a stall was missed upstream.
        if (pipe[1].memRead &&
            ((pipe[0].useRn && writer(pipe[1], pipe[0].rn)) ||
             (pipe[0].useRm && writer(pipe[1], pipe[0].rm)))) begin
            miscompares++;
            $display("FAIL load_fwd_from_exmem: load in EX/MEM feeds EX at %0t", $time);
        end
    end

    function automatic instr_t mk(logic [4:0] rd, logic [4:0] rn, logic [4:0] rm,
                                  bit uRn, bit uRm, bit rw, bit mr);
        instr_t i;
        i.rd = rd; i.rn = rn; i.rm = rm;
        i.useRn = uRn; i.useRm = uRm; i.regWrite = rw; i.memRead = mr;
        return i;
    endfunction

    function automatic instr_t alu(logic [4:0] rd);
        return mk(rd, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic instr_t ld(logic [4:0] rd);
        return mk(rd, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    endfunction

    function automatic instr_t rdRn(logic [4:0] rn);
        return mk(5'd0, rn, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic instr_t rdRm(logic [4:0] rm);
        return mk(5'd0, 5'd0, rm, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    localparam instr_t NOP = '0;

    task automatic drive(instr_t i, bit fl);
        @(negedge clk);
        curIn    = i;
        curFlush = fl;
        busA.Rn_0 = i.rn; busA.Rm_0 = i.rm; busA.useRn_0 = i.useRn; busA.useRm_0 = i.useRm;
        busA.Rd_0 = i.rd; busA.RegWrite_0 = i.regWrite; busA.MemRead_0 = i.memRead;
        busA.flush = fl;
        busB.Rn_0 = i.rn; busB.Rm_0 = i.rm; busB.useRn_0 = i.useRn; busB.useRm_0 = i.useRm;
        busB.Rd_0 = i.rd; busB.RegWrite_0 = i.regWrite; busB.MemRead_0 = i.memRead;
        busB.flush = fl;
        #3;
    endtask

    // Asserts reset between edges and checks the outputs clear before any edge.
    task automatic resetPulse();
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("rst_stall",  32'(busA.stall),      32'd0);
        check("rst_fwdA",   32'(busA.fwdA),       32'd0);
        check("rst_fwdB",   32'(busA.fwdB),       32'd0);
        check("rst_count",  32'(busA.stallCount), 32'd0);
        check("rst_count2", 32'(busB.stallCount), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    function automatic logic [4:0] randReg();
        int v;
        v = $urandom_range(0, 4);
        return (v == 4) ? 5'd31 : 5'(v);
    endfunction

    initial begin
        drive(mk(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1), 1'b0);
        @(negedge clk);
        #1 reset = 1'b1;

        // First instruction only in decode: outputs still at reset values.
        drive(mk(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0);
        check("first_stall", 32'(busA.stall),      32'd0);
        check("first_fwdA",  32'(busA.fwdA),       32'd0);
        check("first_count", 32'(busA.stallCount), 32'd0);

        // Back-to-back ALU dependency.
        drive(alu(5'd3), 1'b0);
        drive(rdRn(5'd3), 1'b0);
        drive(NOP, 1'b0);
        check("exmem_fwdA", 32'(busA.fwdA), 32'd1);

        // One instruction between.
        drive(alu(5'd3), 1'b0);
        drive(NOP, 1'b0);
        drive(rdRn(5'd3), 1'b0);
        drive(NOP, 1'b0);
        check("memwb_fwdA", 32'(busA.fwdA), 32'd2);

        // Two instructions between.
        drive(alu(5'd3), 1'b0);
        drive(NOP, 1'b0);
        drive(NOP, 1'b0);
        drive(rdRn(5'd3), 1'b0);
        drive(NOP, 1'b0);
        check("far_fwdA", 32'(busA.fwdA), 32'd0);

        // Load-use: one stall cycle, then forward from MEM/WB.
        drive(ld(5'd5), 1'b0);
        drive(rdRm(5'd5), 1'b0);
        check("lu_stall", 32'(busA.stall), 32'd1);
        drive(rdRm(5'd5), 1'b0);
        check("lu_stall_gone", 32'(busA.stall),      32'd0);
        check("lu_count",      32'(busA.stallCount), 32'd1);
        drive(NOP, 1'b0);
        check("lu_fwdB", 32'(busA.fwdB), 32'd2);

        // Two back-to-back writers: youngest wins.
        drive(alu(5'd5), 1'b0);
        drive(alu(5'd5), 1'b0);
        drive(rdRn(5'd5), 1'b0);
        drive(NOP, 1'b0);
        check("youngest_fwdA", 32'(busA.fwdA), 32'd1);

        // XZR is never forwarded and never a hazard source.
        drive(alu(5'd31), 1'b0);
        drive(mk(5'd0, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
        drive(NOP, 1'b0);
        check("xzr_fwdA", 32'(busA.fwdA), 32'd0);
        check("xzr_fwdB", 32'(busA.fwdB), 32'd0);
        drive(ld(5'd31), 1'b0);
        drive(rdRn(5'd31), 1'b0);
        check("xzr_stall", 32'(busA.stall), 32'd0);

        // Matching Rn but not read.
        drive(alu(5'd4), 1'b0);
        drive(mk(5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        drive(NOP, 1'b0);
        check("nouse_fwdA", 32'(busA.fwdA), 32'd0);

        // Flush beats load-use: no stall, bubble inserted, count unchanged.
        drive(ld(5'd7), 1'b0);
        drive(mk(5'd9, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
        check("flush_stall", 32'(busA.stall), 32'd0);
        drive(rdRn(5'd9), 1'b0);
        check("flush_next_stall", 32'(busA.stall), 32'd0);
        drive(NOP, 1'b0);
        check("flush_bubble_fwdA", 32'(busA.fwdA),       32'd0);
        check("flush_count",       32'(busA.stallCount), 32'd1);

        // Counter saturation on the 2-bit instance: 1, 2, 3, 3, 3.
        resetPulse();
        for (int k = 0; k < 5; k++) begin
            drive(ld(5'd5), 1'b0);
            drive(rdRm(5'd5), 1'b0);
            drive(rdRm(5'd5), 1'b0);
            check("sat_count2", 32'(busB.stallCount), (k < 3) ? 32'(k + 1) : 32'd3);
            check("sat_count",  32'(busA.stallCount), 32'(k + 1));
        end

        // Randomized traffic; upstream holds the decode instruction on stall.
        for (int n = 0; n < 1500; n++) begin
            instr_t i;
            bit     fl;
            if (n == 700) resetPulse();
            fl = ($urandom_range(0, 9) == 0);
            if (lastStall) begin
                i = curIn;
            end else begin
                i.rn       = randReg();
                i.rm       = randReg();
                i.rd       = randReg();
                i.useRn    = 1'($urandom_range(0, 1));
                i.useRm    = 1'($urandom_range(0, 1));
                i.regWrite = ($urandom_range(0, 3) != 0);
                i.memRead  = ($urandom_range(0, 2) == 0);
            end
            drive(i, fl);
        end

        drive(NOP, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
